// File: rtl/kbd_lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kbd_lcd_pkg
// Description : Shared key/LCD code constants and the edit sequencer state
//               type used by the keyboard-to-LCD line editing path.
// Revision    : 1.0 - initial release
// ============================================================================
package kbd_lcd_pkg;

    // Width of a decoded LCD character code
    localparam int LCD_CODE_W = 9;

    // Special decoded key codes
    localparam logic [LCD_CODE_W-1:0] KEY_ENTER = 9'h108;
    localparam logic [LCD_CODE_W-1:0] KEY_BKSP  = 9'h109;

    // Blank character written on erase and line clear
    localparam logic [LCD_CODE_W-1:0] KEY_SPACE = 9'h120;

    // Edit sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } edit_state_t;

endpackage : kbd_lcd_pkg
`default_nettype wire

// File: rtl/line_edit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_edit_ctrl
// Description : Edit controller between the PS/2 key decoder and the two LCD
//               line buffers. Owns the cursor, sequences buffer writes for
//               printable, backspace and enter keys (enter clears the new
//               line), holds off writes while the LCD refresh is reading the
//               buffers and pulses a refresh request after every edit.
//               Optional build macro AUTO_WRAP_EN: a printable key typed on a
//               full line moves to the other line, clears it and places the
//               character in column 0. Without it such a key is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module line_edit_ctrl
    import kbd_lcd_pkg::*;
#(
    parameter int                COLS       = 16,
    parameter int                CODE_W     = LCD_CODE_W,
    parameter logic [CODE_W-1:0] ENTER_CODE = KEY_ENTER,
    parameter logic [CODE_W-1:0] BKSP_CODE  = KEY_BKSP,
    parameter logic [CODE_W-1:0] SPACE_CODE = KEY_SPACE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_valid,
    input  logic [CODE_W-1:0]          key_code,
    output logic                       key_ready,
    input  logic                       lcd_busy,
    output logic                       wr_en,
    output logic                       wr_line,
    output logic [$clog2(COLS)-1:0]    wr_addr,
    output logic [CODE_W-1:0]          wr_data,
    output logic                       refresh_req,
    output logic                       cur_line,
    output logic [$clog2(COLS+1)-1:0]  cur_col,
    output logic                       line_full
);

    // Column address width and cursor/counter width (cursor may sit at COLS)
    localparam int AW = $clog2(COLS);
    localparam int CW = $clog2(COLS + 1);

    localparam logic [CW-1:0] COLS_CW = CW'(COLS);
    localparam logic [CW-1:0] LAST_CW = CW'(COLS - 1);
    localparam logic [CW-1:0] ONE_CW  = CW'(1);

    edit_state_t         state;
    logic [CODE_W-1:0]   key_latch;   // key being executed
    logic [CW-1:0]       clr_cnt;     // next column to blank during CLEAR
    logic                wrap_pend;   // a wrapped character waits for the clear to finish

    logic                is_enter;
    logic                is_bksp;
    logic                at_end;

    // Key classification and cursor-at-end flag
    always_comb begin
        is_enter = (key_latch == ENTER_CODE);
        is_bksp  = (key_latch == BKSP_CODE);
        at_end   = (cur_col == COLS_CW);
    end

    assign line_full = at_end;

    // Edit sequencer: key capture, cursor update, buffer write strobes and refresh pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            key_ready   <= 1'b1;
            wr_en       <= 1'b0;
            wr_line     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= SPACE_CODE;
            refresh_req <= 1'b0;
            cur_line    <= 1'b0;
            cur_col     <= '0;
            key_latch   <= SPACE_CODE;
            clr_cnt     <= '0;
            wrap_pend   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            wr_en       <= 1'b0;
            refresh_req <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        key_latch <= key_code;
                        key_ready <= 1'b0;
                        state     <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    // Nothing moves while the LCD owns the buffers
                    if (!lcd_busy) begin
                        if (is_enter) begin
                            // Column 0 of the new line is blanked right away;
                            // CLEAR continues from column 1.
                            cur_line <= ~cur_line;
                            cur_col  <= '0;
                            wr_en    <= 1'b1;
                            wr_line  <= ~cur_line;
                            wr_addr  <= '0;
                            wr_data  <= SPACE_CODE;
                            clr_cnt  <= ONE_CW;
                            state    <= ST_CLEAR;
                        end else if (is_bksp) begin
                            if (cur_col == '0) begin
                                // Nothing to erase: no write, no refresh
                                key_ready <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                wr_en   <= 1'b1;
                                wr_line <= cur_line;
                                wr_addr <= AW'(cur_col - ONE_CW);
                                wr_data <= SPACE_CODE;
                                cur_col <= cur_col - ONE_CW;
                                state   <= ST_DONE;
                            end
                        end else if (!at_end) begin
                            wr_en   <= 1'b1;
                            wr_line <= cur_line;
                            wr_addr <= AW'(cur_col);
                            wr_data <= key_latch;
                            cur_col <= cur_col + ONE_CW;
                            state   <= ST_DONE;
                        end else begin
`ifdef AUTO_WRAP_EN
                            // Move to the other line, clear it, then place the character
                            cur_line  <= ~cur_line;
                            cur_col   <= '0;
                            wr_en     <= 1'b1;
                            wr_line   <= ~cur_line;
                            wr_addr   <= '0;
                            wr_data   <= SPACE_CODE;
                            clr_cnt   <= ONE_CW;
                            wrap_pend <= 1'b1;
                            state     <= ST_CLEAR;
`else
                            // Line is full: the character is discarded
                            key_ready <= 1'b1;
                            state     <= ST_IDLE;
`endif
                        end
                    end
                end

                ST_CLEAR: begin
                    // Busy cycles skip and hold the column counter
                    if (!lcd_busy) begin
                        if (clr_cnt != COLS_CW) begin
                            wr_en   <= 1'b1;
                            wr_line <= cur_line;
                            wr_addr <= clr_cnt[AW-1:0];
                            wr_data <= SPACE_CODE;
                            clr_cnt <= clr_cnt + ONE_CW;
                            if ((clr_cnt == LAST_CW) && !wrap_pend) begin
                                state <= ST_DONE;
                            end
                        end else if (wrap_pend) begin
                            // Line blanked: drop the wrapped character into column 0
                            wr_en     <= 1'b1;
                            wr_line   <= cur_line;
                            wr_addr   <= '0;
                            wr_data   <= key_latch;
                            cur_col   <= ONE_CW;
                            wrap_pend <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    refresh_req <= 1'b1;
                    key_ready   <= 1'b1;
                    state       <= ST_IDLE;
                end

                default: begin
                    key_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : line_edit_ctrl
`default_nettype wire

// File: tb/tb_line_edit_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_line_edit_ctrl
// Description : Self-checking bench for line_edit_ctrl. A behavioural model of
//               the two LCD lines and the cursor predicts every buffer write
//               and refresh; a monitor captures what the controller issues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_edit_ctrl;

    localparam int COLS = 16;
    localparam logic [8:0] C_ENTER = 9'h108;
    localparam logic [8:0] C_BKSP  = 9'h109;
    localparam logic [8:0] C_SPACE = 9'h120;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [8:0] key_code;
    logic       key_ready;
    logic       lcd_busy;
    logic       wr_en;
    logic       wr_line;
    logic [3:0] wr_addr;
    logic [8:0] wr_data;
    logic       refresh_req;
    logic       cur_line;
    logic [4:0] cur_col;
    logic       line_full;

    line_edit_ctrl #(.COLS(COLS)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .lcd_busy    (lcd_busy),
        .wr_en       (wr_en),
        .wr_line     (wr_line),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .refresh_req (refresh_req),
        .cur_line    (cur_line),
        .cur_col     (cur_col),
        .line_full   (line_full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       line;
        logic [3:0] addr;
        logic [8:0] data;
    } wr_t;

    function automatic wr_t mk(input logic l, input int a, input logic [8:0] d);
        wr_t w;
        w.line = l;
        w.addr = a[3:0];
        w.data = d;
        return w;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Observed activity
    wr_t        obs_q[$];
    int         wcyc_q[$];
    int         ref_cnt   = 0;
    int         ref_cyc   = 0;
    int         busy_viol = 0;
    logic       busy_at_edge;
    logic [8:0] d_buf [2][COLS];

    // Reference model
    wr_t        exp_q[$];
    int         exp_ref;
    int         m_line;
    int         m_col;
    logic [8:0] m_buf [2][COLS];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every write and refresh, flags writes issued while busy
    always @(posedge clk) begin
        busy_at_edge = lcd_busy;
        #1;
        if (wr_en === 1'b1) begin
            if (busy_at_edge === 1'b1) busy_viol++;
            obs_q.push_back(mk(wr_line, int'(wr_addr), wr_data));
            wcyc_q.push_back(cyc);
            d_buf[wr_line][wr_addr] = wr_data;
        end
        if (refresh_req === 1'b1) begin
            ref_cnt++;
            ref_cyc = cyc;
        end
    end

    // Model of one key: edits the line images and lists the writes it implies
    task automatic model_key(input logic [8:0] code);
        exp_q.delete();
        exp_ref = 0;
        if (code == C_ENTER) begin
            m_line = 1 - m_line;
            m_col  = 0;
            for (int a = 0; a < COLS; a++) exp_q.push_back(mk(m_line[0], a, C_SPACE));
            exp_ref = 1;
        end else if (code == C_BKSP) begin
            if (m_col > 0) begin
                m_col = m_col - 1;
                exp_q.push_back(mk(m_line[0], m_col, C_SPACE));
                exp_ref = 1;
            end
        end else if (m_col < COLS) begin
            exp_q.push_back(mk(m_line[0], m_col, code));
            m_col   = m_col + 1;
            exp_ref = 1;
        end else begin
`ifdef AUTO_WRAP_EN
            m_line = 1 - m_line;
            for (int a = 0; a < COLS; a++) exp_q.push_back(mk(m_line[0], a, C_SPACE));
            exp_q.push_back(mk(m_line[0], 0, code));
            m_col   = 1;
            exp_ref = 1;
`endif
        end
        foreach (exp_q[i]) m_buf[exp_q[i].line][exp_q[i].addr] = exp_q[i].data;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; key_valid = 1'b0; lcd_busy = 1'b0; key_code = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_line = 0; m_col = 0;
        obs_q.delete(); wcyc_q.delete(); ref_cnt = 0;
    endtask

    // Present one key (called at a negedge with the controller idle), wait for completion
    task automatic do_key(input logic [8:0] code, input bit rnd_busy, output int acc, output int done);
        int n;
        obs_q.delete(); wcyc_q.delete(); ref_cnt = 0;
        key_valid = 1'b1; key_code = code;
        lcd_busy  = rnd_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
        @(posedge clk); #2;
        acc = cyc; key_valid = 1'b0;
        n = 0;
        while (key_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            lcd_busy = rnd_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
            @(posedge clk); #2;
            n++;
        end
        done = cyc;
        n_checks++;
        if (key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL key_timeout code=%h: key_ready=%b required 1", code, key_ready);
        end
        @(negedge clk);
        lcd_busy = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks += 9;
        if (key_ready   !== 1'b1)    begin n_fail++; $display("FAIL reset_key_ready: got %b required 1", key_ready); end
        if (wr_en       !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_en: got %b required 0", wr_en); end
        if (wr_line     !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_line: got %b required 0", wr_line); end
        if (wr_addr     !== 4'd0)    begin n_fail++; $display("FAIL reset_wr_addr: got %h required 0", wr_addr); end
        if (wr_data     !== C_SPACE) begin n_fail++; $display("FAIL reset_wr_data: got %h required %h", wr_data, C_SPACE); end
        if (refresh_req !== 1'b0)    begin n_fail++; $display("FAIL reset_refresh: got %b required 0", refresh_req); end
        if (cur_line    !== 1'b0)    begin n_fail++; $display("FAIL reset_cur_line: got %b required 0", cur_line); end
        if (cur_col     !== 5'd0)    begin n_fail++; $display("FAIL reset_cur_col: got %0d required 0", cur_col); end
        if (line_full   !== 1'b0)    begin n_fail++; $display("FAIL reset_line_full: got %b required 0", line_full); end
    endtask

    task automatic test_single_key();
        int acc, done;
        apply_reset();
        model_key(9'h141);
        do_key(9'h141, 1'b0, acc, done);
        n_checks += 6;
        if (obs_q.size() != 1 || obs_q[0] !== mk(1'b0, 0, 9'h141))
            begin n_fail++; $display("FAIL single_write: got %0d writes first=%h required 1 write %h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, mk(1'b0, 0, 9'h141)); end
        if (wcyc_q.size() != 1 || wcyc_q[0] != acc + 1)
            begin n_fail++; $display("FAIL single_wr_latency: got cycle %0d required %0d", wcyc_q.size() ? wcyc_q[0] - acc : -1, 1); end
        if (ref_cnt != 1)        begin n_fail++; $display("FAIL single_refresh_count: got %0d required 1", ref_cnt); end
        if (ref_cyc != acc + 2)  begin n_fail++; $display("FAIL single_refresh_latency: got %0d required 2", ref_cyc - acc); end
        if (done != acc + 2)     begin n_fail++; $display("FAIL single_ready_latency: got %0d required 2", done - acc); end
        if (cur_col !== 5'd1)    begin n_fail++; $display("FAIL single_cur_col: got %0d required 1", cur_col); end
    endtask

    task automatic test_backspace();
        int acc, done;
        apply_reset();
        model_key(C_BKSP);
        do_key(C_BKSP, 1'b0, acc, done);
        n_checks += 3;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL bksp_col0_write: got %0d writes required 0", obs_q.size()); end
        if (ref_cnt != 0)      begin n_fail++; $display("FAIL bksp_col0_refresh: got %0d required 0", ref_cnt); end
        if (cur_col !== 5'd0)  begin n_fail++; $display("FAIL bksp_col0_cur_col: got %0d required 0", cur_col); end
        for (int i = 0; i < 3; i++) begin
            model_key(9'h141 + 9'(i));
            do_key(9'h141 + 9'(i), 1'b0, acc, done);
        end
        model_key(C_BKSP);
        do_key(C_BKSP, 1'b0, acc, done);
        n_checks += 3;
        if (obs_q.size() != 1 || obs_q[0] !== mk(1'b0, 2, C_SPACE))
            begin n_fail++; $display("FAIL bksp_write: got %0d writes first=%h required %h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, mk(1'b0, 2, C_SPACE)); end
        if (ref_cnt != 1)     begin n_fail++; $display("FAIL bksp_refresh: got %0d required 1", ref_cnt); end
        if (cur_col !== 5'd2) begin n_fail++; $display("FAIL bksp_cur_col: got %0d required 2", cur_col); end
    endtask

    task automatic test_enter();
        int acc, done, bad;
        logic [8:0] c;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            c = 9'($urandom_range(9'h121, 9'h17e));
            model_key(c);
            do_key(c, 1'b0, acc, done);
        end
        model_key(C_ENTER);
        do_key(C_ENTER, 1'b0, acc, done);
        bad = -1;
        foreach (obs_q[i]) if (obs_q[i] !== mk(1'b1, i, C_SPACE) && bad < 0) bad = i;
        n_checks += 7;
        if (obs_q.size() != COLS) begin n_fail++; $display("FAIL enter_write_count: got %0d required %0d", obs_q.size(), COLS); end
        if (bad >= 0)             begin n_fail++; $display("FAIL enter_write_entry %0d: got %h required %h", bad, obs_q[bad], mk(1'b1, bad, C_SPACE)); end
        if (wcyc_q.size() != COLS || wcyc_q[0] != acc + 1 || wcyc_q[COLS-1] != acc + COLS)
            begin n_fail++; $display("FAIL enter_write_timing: got first=%0d last=%0d required 1 and %0d", wcyc_q.size() ? wcyc_q[0] - acc : -1, wcyc_q.size() ? wcyc_q[wcyc_q.size()-1] - acc : -1, COLS); end
        if (ref_cnt != 1)               begin n_fail++; $display("FAIL enter_refresh_count: got %0d required 1", ref_cnt); end
        if (ref_cyc != acc + COLS + 1)  begin n_fail++; $display("FAIL enter_refresh_latency: got %0d required %0d", ref_cyc - acc, COLS + 1); end
        if (cur_line !== 1'b1)          begin n_fail++; $display("FAIL enter_cur_line: got %b required 1", cur_line); end
        if (cur_col !== 5'd0)           begin n_fail++; $display("FAIL enter_cur_col: got %0d required 0", cur_col); end
    endtask

    task automatic test_full_line();
        int acc, done, bad;
        logic [8:0] c;
        apply_reset();
        for (int i = 0; i < COLS; i++) begin
            c = 9'($urandom_range(9'h121, 9'h17e));
            model_key(c);
            do_key(c, 1'b0, acc, done);
        end
        n_checks += 2;
        if (line_full !== 1'b1)  begin n_fail++; $display("FAIL full_line_full: got %b required 1", line_full); end
        if (cur_col !== 5'd16)   begin n_fail++; $display("FAIL full_cur_col: got %0d required 16", cur_col); end
        c = 9'h15a;
        model_key(c);
        do_key(c, 1'b0, acc, done);
        bad = -1;
        if (obs_q.size() == exp_q.size())
            foreach (obs_q[i]) if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
        n_checks += 6;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL overflow_write_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        if (bad >= 0)                     begin n_fail++; $display("FAIL overflow_write_entry %0d: got %h required %h", bad, obs_q[bad], exp_q[bad]); end
        if (ref_cnt != exp_ref)           begin n_fail++; $display("FAIL overflow_refresh: got %0d required %0d", ref_cnt, exp_ref); end
        if (cur_col !== 5'(m_col))        begin n_fail++; $display("FAIL overflow_cur_col: got %0d required %0d", cur_col, m_col); end
        if (cur_line !== m_line[0])       begin n_fail++; $display("FAIL overflow_cur_line: got %b required %0d", cur_line, m_line); end
        if (line_full !== (m_col == COLS)) begin n_fail++; $display("FAIL overflow_line_full: got %b required %0d", line_full, m_col == COLS); end
    endtask

    task automatic test_busy();
        int acc, n, bad;
        apply_reset();
        // Busy across the whole execute step
        model_key(9'h141);
        obs_q.delete(); ref_cnt = 0;
        key_valid = 1'b1; key_code = 9'h141; lcd_busy = 1'b1;
        @(posedge clk); #2;
        key_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        n_checks += 1;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL busy_exec_write: got %0d writes required 0", obs_q.size()); end
        @(negedge clk); lcd_busy = 1'b0;
        n = 0;
        while (key_ready !== 1'b1 && n < 20) begin @(posedge clk); #2; n++; end
        n_checks += 3;
        if (key_ready !== 1'b1) begin n_fail++; $display("FAIL busy_exec_timeout: key_ready=%b required 1", key_ready); end
        if (obs_q.size() != 1 || obs_q[0] !== mk(1'b0, 0, 9'h141))
            begin n_fail++; $display("FAIL busy_exec_result: got %0d writes first=%h required %h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, mk(1'b0, 0, 9'h141)); end
        if (ref_cnt != 1) begin n_fail++; $display("FAIL busy_exec_refresh: got %0d required 1", ref_cnt); end
        // Busy in the middle of a line clear
        @(negedge clk);
        model_key(C_ENTER);
        obs_q.delete(); ref_cnt = 0;
        key_valid = 1'b1; key_code = C_ENTER;
        @(posedge clk); #2;
        acc = cyc; key_valid = 1'b0;
        n = 0;
        while (obs_q.size() < 5 && n < 40) begin @(posedge clk); #2; n++; end
        @(negedge clk); lcd_busy = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        n_checks += 1;
        if (obs_q.size() != 5) begin n_fail++; $display("FAIL busy_clear_hold: got %0d writes required 5", obs_q.size()); end
        @(negedge clk); lcd_busy = 1'b0;
        n = 0;
        while (key_ready !== 1'b1 && n < 60) begin @(posedge clk); #2; n++; end
        bad = -1;
        foreach (obs_q[i]) if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
        n_checks += 4;
        if (obs_q.size() != COLS) begin n_fail++; $display("FAIL busy_clear_count: got %0d required %0d", obs_q.size(), COLS); end
        if (bad >= 0)             begin n_fail++; $display("FAIL busy_clear_entry %0d: got %h required %h", bad, obs_q[bad], exp_q[bad]); end
        if (ref_cnt != 1)         begin n_fail++; $display("FAIL busy_clear_refresh: got %0d required 1", ref_cnt); end
        if (busy_viol != 0)       begin n_fail++; $display("FAIL busy_write_while_busy: got %0d required 0", busy_viol); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_clear();
        int n;
        apply_reset();
        obs_q.delete(); ref_cnt = 0;
        key_valid = 1'b1; key_code = C_ENTER;
        @(posedge clk); #2;
        key_valid = 1'b0;
        n = 0;
        while (obs_q.size() < 8 && n < 40) begin @(posedge clk); #2; n++; end
        n_checks += 1;
        if (obs_q.size() != 8 || obs_q[7] !== mk(1'b1, 7, C_SPACE))
            begin n_fail++; $display("FAIL midclear_reach_addr7: got %0d writes required 8", obs_q.size()); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #2;
        n_checks += 9;
        if (key_ready   !== 1'b1)    begin n_fail++; $display("FAIL midclear_key_ready: got %b required 1", key_ready); end
        if (wr_en       !== 1'b0)    begin n_fail++; $display("FAIL midclear_wr_en: got %b required 0", wr_en); end
        if (wr_line     !== 1'b0)    begin n_fail++; $display("FAIL midclear_wr_line: got %b required 0", wr_line); end
        if (wr_addr     !== 4'd0)    begin n_fail++; $display("FAIL midclear_wr_addr: got %h required 0", wr_addr); end
        if (wr_data     !== C_SPACE) begin n_fail++; $display("FAIL midclear_wr_data: got %h required %h", wr_data, C_SPACE); end
        if (refresh_req !== 1'b0)    begin n_fail++; $display("FAIL midclear_refresh: got %b required 0", refresh_req); end
        if (cur_line    !== 1'b0)    begin n_fail++; $display("FAIL midclear_cur_line: got %b required 0", cur_line); end
        if (cur_col     !== 5'd0)    begin n_fail++; $display("FAIL midclear_cur_col: got %0d required 0", cur_col); end
        if (line_full   !== 1'b0)    begin n_fail++; $display("FAIL midclear_line_full: got %b required 0", line_full); end
        @(negedge clk); rst = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        n_checks += 2;
        if (obs_q.size() != 8) begin n_fail++; $display("FAIL midclear_no_more_writes: got %0d writes required 8", obs_q.size()); end
        if (ref_cnt != 0)      begin n_fail++; $display("FAIL midclear_no_refresh: got %0d required 0", ref_cnt); end
        @(negedge clk);
        m_line = 0; m_col = 0;
    endtask

    task automatic test_random();
        int acc, done, bad, r, buf_bad;
        logic [8:0] c;
        apply_reset();
        for (int l = 0; l < 2; l++)
            for (int a = 0; a < COLS; a++) begin d_buf[l][a] = C_SPACE; m_buf[l][a] = C_SPACE; end
        busy_viol = 0;
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 11);
            if (r == 0)      c = C_ENTER;
            else if (r <= 2) c = C_BKSP;
            else             c = 9'($urandom_range(9'h121, 9'h17e));
            model_key(c);
            do_key(c, k[0], acc, done);
            bad = -1;
            if (obs_q.size() == exp_q.size())
                foreach (obs_q[i]) if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
            n_checks += 6;
            if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_write_count key%0d code=%h: got %0d required %0d", k, c, obs_q.size(), exp_q.size()); end
            if (bad >= 0)                     begin n_fail++; $display("FAIL rand_write_entry key%0d: got %h required %h", k, obs_q[bad], exp_q[bad]); end
            if (ref_cnt != exp_ref)           begin n_fail++; $display("FAIL rand_refresh key%0d: got %0d required %0d", k, ref_cnt, exp_ref); end
            if (cur_line !== m_line[0])       begin n_fail++; $display("FAIL rand_cur_line key%0d: got %b required %0d", k, cur_line, m_line); end
            if (cur_col !== 5'(m_col))        begin n_fail++; $display("FAIL rand_cur_col key%0d: got %0d required %0d", k, cur_col, m_col); end
            if (line_full !== (m_col == COLS)) begin n_fail++; $display("FAIL rand_line_full key%0d: got %b required %0d", k, line_full, m_col == COLS); end
        end
        buf_bad = 0;
        for (int l = 0; l < 2; l++)
            for (int a = 0; a < COLS; a++) if (d_buf[l][a] !== m_buf[l][a]) buf_bad++;
        n_checks += 2;
        if (buf_bad != 0)   begin n_fail++; $display("FAIL rand_buffer_image: got %0d differing cells required 0", buf_bad); end
        if (busy_viol != 0) begin n_fail++; $display("FAIL rand_write_while_busy: got %0d required 0", busy_viol); end
    endtask

    initial begin
        rst = 1'b0; key_valid = 1'b0; key_code = '0; lcd_busy = 1'b0;
        m_line = 0; m_col = 0;
        test_reset();
        test_single_key();
        test_backspace();
        test_enter();
        test_full_line();
        test_busy();
        test_reset_mid_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_line_edit_ctrl
`default_nettype wire
